// File: rtl/dht11_pkg.sv
// Shared types and timing constants for the DHT11 sensor-side responder.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    ACK_WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_e;

  localparam int unsigned RESP_US    = 80;
  localparam int unsigned BIT_LOW_US = 50;
  localparam int unsigned BIT0_US    = 26;
  localparam int unsigned BIT1_US    = 70;
  localparam int unsigned END_US     = 50;
  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned US_W       = 20;

  function automatic logic [7:0] dht11_chk(input logic [7:0] h, input logic [7:0] t);
    return h + t;
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// 1 us tick prescaler; i_clr restarts the period so each phase starts on a tick boundary.
module dht11_us_tick #(
  parameter int unsigned DIV = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               r_cnt <= '0;
    else if (i_clr || o_tick)  r_cnt <= '0;
    else                       r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with a 40-bit humidity/temperature frame.
// Optional DHT11_FAULT_INJ_EN adds chk_err_i, which inverts the transmitted checksum byte.
module dht11_responder import dht11_pkg::*; #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned ACK_DELAY_US = 30
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       dht_i,
  output logic       dht_oe_o,
  input  logic [7:0] hum_i,
  input  logic [7:0] temp_i,
`ifdef DHT11_FAULT_INJ_EN
  input  logic       chk_err_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  state_e          r_state, w_state_nxt;
  logic [1:0]      r_sync;
  logic            r_line_q;
  logic [US_W-1:0] r_us, w_width;
  logic [1:0]      r_col;
  logic [5:0]      r_bit;
  logic [FRAME_BITS-1:0] r_frame;
  logic [7:0]      w_chk;
  logic            w_line, w_tick, w_clr, w_end, w_col, w_accept, w_col_st;
  logic            w_oe_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

`ifdef DHT11_FAULT_INJ_EN
  assign w_chk = dht11_chk(hum_i, temp_i) ^ {8{chk_err_i}};
`else
  assign w_chk = dht11_chk(hum_i, temp_i);
`endif

  // Synchroniser resets high so a released line never looks like a start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync   <= 2'b11;
      r_line_q <= 1'b1;
    end else begin
      r_sync   <= {r_sync[0], dht_i};
      r_line_q <= w_line;
    end
  end
  assign w_line = r_sync[1];

  dht11_us_tick #(.DIV(CLK_HZ / 1_000_000)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_width = '1;
    case (r_state)
      ACK_WAIT:            w_width = US_W'(ACK_DELAY_US);
      RESP_LOW, RESP_HIGH: w_width = US_W'(RESP_US);
      BIT_LOW:             w_width = US_W'(BIT_LOW_US);
      BIT_HIGH:            w_width = r_frame[FRAME_BITS-1] ? US_W'(BIT1_US) : US_W'(BIT0_US);
      END_LOW:             w_width = US_W'(END_US);
      default:             w_width = '1;
    endcase
  end

  assign w_clr    = (w_state_nxt != r_state);
  assign w_end    = w_tick && (r_us == w_width - 1'b1);
  assign w_col_st = (r_state == ACK_WAIT) || (r_state == RESP_HIGH) || (r_state == BIT_HIGH);
  // Second consecutive low tick in a released phase means someone else is driving.
  assign w_col    = w_col_st && w_tick && !w_line && (r_col != 2'b00);
  assign w_accept = (r_state == START_LOW) && w_line && (r_us >= US_W'(START_MIN_US));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_us    <= '0;
      r_col   <= '0;
      r_bit   <= '0;
      r_frame <= '0;
    end else begin
      if (w_clr)                       r_us <= '0;
      else if (w_tick && r_us != '1)   r_us <= r_us + 1'b1;

      if (w_clr || w_line)             r_col <= '0;
      else if (w_tick && r_col != 2'b11) r_col <= r_col + 1'b1;

      if (w_accept) begin
        r_frame <= {hum_i, 8'h00, temp_i, 8'h00, w_chk};
        r_bit   <= '0;
      end else if (r_state == BIT_HIGH && w_end) begin
        r_frame <= r_frame << 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (r_line_q && !w_line) w_state_nxt = START_LOW;
      START_LOW: if (w_line)              w_state_nxt = w_accept ? ACK_WAIT : IDLE;
      ACK_WAIT:  if (w_col)               w_state_nxt = IDLE;
                 else if (w_end)          w_state_nxt = RESP_LOW;
      RESP_LOW:  if (w_end)               w_state_nxt = RESP_HIGH;
      RESP_HIGH: if (w_col)               w_state_nxt = IDLE;
                 else if (w_end)          w_state_nxt = BIT_LOW;
      BIT_LOW:   if (w_end)               w_state_nxt = BIT_HIGH;
      BIT_HIGH:  if (w_col)               w_state_nxt = IDLE;
                 else if (w_end)          w_state_nxt = (r_bit == 6'(FRAME_BITS - 1)) ? END_LOW : BIT_LOW;
      END_LOW:   if (w_end)               w_state_nxt = IDLE;
      default:                            w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change with the state.
  always_comb begin
    w_oe_nxt   = (w_state_nxt == RESP_LOW) || (w_state_nxt == BIT_LOW) || (w_state_nxt == END_LOW);
    w_busy_nxt = (w_state_nxt != IDLE) && (w_state_nxt != START_LOW);
    w_done_nxt = (r_state == END_LOW) && w_end;
    w_err_nxt  = w_col;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dht_oe_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      dht_oe_o <= w_oe_nxt;
      busy_o   <= w_busy_nxt;
      done_o   <= w_done_nxt;
      err_o    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder: host model on an open-drain line, frame decoder, scoreboard.
`timescale 1ns/1ps
module tb_dht11_responder;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] hum_i = 8'd0;
  logic [7:0] temp_i = 8'd0;
  logic       dht_i, dht_oe_o, busy_o, done_o, err_o;
`ifdef DHT11_FAULT_INJ_EN
  logic       chk_err_i = 1'b0;
`endif

  assign dht_i = ~(dht_oe_o | host_low);
  always #5 clk = ~clk;

  dht11_responder #(
    .CLK_HZ       (2_000_000),
    .START_MIN_US (100),
    .ACK_DELAY_US (30)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .dht_i    (dht_i),
    .dht_oe_o (dht_oe_o),
    .hum_i    (hum_i),
    .temp_i   (temp_i),
`ifdef DHT11_FAULT_INJ_EN
    .chk_err_i(chk_err_i),
`endif
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];

  always @(negedge clk) begin
    if (done_o) n_done <= n_done + 1;
    if (err_o)  n_err  <= n_err + 1;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got timeout want summary");
    $fatal(1);
  end

  task automatic wait_oe(input logic lvl, input int max_us, output int cyc, output logic to);
    cyc = 0;
    to  = 1'b0;
    while (dht_oe_o !== lvl && !to) begin
      @(negedge clk);
      cyc++;
      if (cyc > max_us * DIV) to = 1'b1;
    end
  endtask

  task automatic host_start(input int us);
    repeat (10 * DIV) @(negedge clk);
    host_low = 1'b1;
    repeat (us * DIV) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_rises(input int n, output logic to);
    int c;
    logic t;
    to = 1'b0;
    for (int i = 0; i < n && !to; i++) begin
      wait_oe(1'b1, 300, c, t); to |= t;
      if (i < n - 1 && !to) begin
        wait_oe(1'b0, 300, c, t); to |= t;
      end
    end
  endtask

  task automatic rx_frame(output logic [39:0] f, output int ack, output int rl, output int rh,
                          output int el, output logic done_end, output logic busy_end, output logic to);
    int c;
    logic t;
    f = '0; to = 1'b0; ack = 0; rl = 0; rh = 0; el = 0;
    wait_oe(1'b1, 300, c, t); to |= t; ack = c / DIV;
    if (!to) begin wait_oe(1'b0, 300, c, t); to |= t; rl = c / DIV; end
    if (!to) begin wait_oe(1'b1, 300, c, t); to |= t; rh = c / DIV; end
    for (int i = 0; i < 40 && !to; i++) begin
      wait_oe(1'b0, 300, c, t); to |= t;
      if (!to) begin wait_oe(1'b1, 300, c, t); to |= t; end
      f = {f[38:0], (c / DIV > 48)};
    end
    if (!to) begin wait_oe(1'b0, 300, c, t); to |= t; el = c / DIV; end
    done_end = done_o;
    busy_end = busy_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({dht_oe_o, busy_o, done_o, err_o} !== 4'b0000)
      $display("FAIL reset_state got %b want 0000", {dht_oe_o, busy_o, done_o, err_o});
    else n_pass++;
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++;
    if ({dht_oe_o, busy_o, done_o, err_o} !== 4'b0000)
      $display("FAIL idle_after_reset got %b want 0000", {dht_oe_o, busy_o, done_o, err_o});
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    logic [39:0] f, e;
    int ack, rl, rh, el, e0;
    logic de, be, to;
    hum_i = 8'd25; temp_i = 8'd25;
    e0 = n_err;
    exp_q.push_back({8'h19, 8'h00, 8'h19, 8'h00, 8'h32});
    host_start(150);
    rx_frame(f, ack, rl, rh, el, de, be, to);
    e = exp_q.pop_front();
    n_chk++; if (to !== 1'b0) $display("FAIL basic_timeout got %b want 0", to); else n_pass++;
    n_chk++; if (f !== e) $display("FAIL basic_frame got %h want %h", f, e); else n_pass++;
    n_chk++; if (ack < 29 || ack > 32) $display("FAIL basic_ack_us got %0d want 30", ack); else n_pass++;
    n_chk++; if (rl < 79 || rl > 81) $display("FAIL basic_resp_low_us got %0d want 80", rl); else n_pass++;
    n_chk++; if (rh < 79 || rh > 81) $display("FAIL basic_resp_high_us got %0d want 80", rh); else n_pass++;
    n_chk++; if (el < 49 || el > 51) $display("FAIL basic_end_low_us got %0d want 50", el); else n_pass++;
    n_chk++; if (de !== 1'b1) $display("FAIL basic_done_at_end got %b want 1", de); else n_pass++;
    n_chk++; if (be !== 1'b0) $display("FAIL basic_busy_at_end got %b want 0", be); else n_pass++;
    @(negedge clk);
    n_chk++; if (done_o !== 1'b0) $display("FAIL basic_done_one_cycle got %b want 0", done_o); else n_pass++;
    n_chk++; if (n_err !== e0) $display("FAIL basic_no_err got %0d want %0d", n_err, e0); else n_pass++;
  endtask

  task automatic test_glitch();
    int d0, e0;
    logic saw;
    d0 = n_done; e0 = n_err; saw = 1'b0;
    host_start(60);
    repeat (300 * DIV) begin
      @(negedge clk);
      if (dht_oe_o || busy_o) saw = 1'b1;
    end
    n_chk++; if (saw !== 1'b0) $display("FAIL glitch_activity got %b want 0", saw); else n_pass++;
    n_chk++;
    if (n_done !== d0 || n_err !== e0)
      $display("FAIL glitch_pulses got done=%0d err=%0d want done=%0d err=%0d", n_done, n_err, d0, e0);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [39:0] f, e;
    int ack, rl, rh, el, d0, e0, c;
    logic de, be, to, t, saw;
    hum_i = 8'h12; temp_i = 8'h34;
    host_start(150);
    repeat (4) @(negedge clk);
    n_chk++; if (busy_o !== 1'b1) $display("FAIL coll_busy_after_accept got %b want 1", busy_o); else n_pass++;
    wait_rises(12, to);
    wait_oe(1'b0, 300, c, t); to |= t;
    n_chk++; if (to !== 1'b0) $display("FAIL coll_reach_bit10 got %b want 0", to); else n_pass++;
    repeat (2) @(negedge clk);
    d0 = n_done; e0 = n_err;
    host_low = 1'b1;
    repeat (5 * DIV) @(negedge clk);
    host_low = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (n_err !== e0 + 1) $display("FAIL coll_err_pulse got %0d want %0d", n_err, e0 + 1); else n_pass++;
    n_chk++;
    if ({dht_oe_o, busy_o} !== 2'b00) $display("FAIL coll_released got %b want 00", {dht_oe_o, busy_o});
    else n_pass++;
    saw = 1'b0;
    repeat (100 * DIV) begin
      @(negedge clk);
      if (dht_oe_o || busy_o) saw = 1'b1;
    end
    n_chk++; if (saw !== 1'b0) $display("FAIL coll_no_restart got %b want 0", saw); else n_pass++;
    n_chk++; if (n_done !== d0) $display("FAIL coll_no_done got %0d want %0d", n_done, d0); else n_pass++;
    // Recovery frame also exercises checksum wrap (0xFF + 0x01).
    hum_i = 8'hFF; temp_i = 8'h01;
`ifdef DHT11_FAULT_INJ_EN
    chk_err_i = 1'b1;
    exp_q.push_back({8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF});
`else
    exp_q.push_back({8'hFF, 8'h00, 8'h01, 8'h00, 8'h00});
`endif
    host_start(150);
    rx_frame(f, ack, rl, rh, el, de, be, to);
`ifdef DHT11_FAULT_INJ_EN
    chk_err_i = 1'b0;
`endif
    e = exp_q.pop_front();
    n_chk++; if (f !== e || to) $display("FAIL coll_recovery_frame got %h want %h", f, e); else n_pass++;
    n_chk++; if (de !== 1'b1) $display("FAIL coll_recovery_done got %b want 1", de); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    logic to, saw;
    hum_i = 8'd25; temp_i = 8'd25;
    host_start(150);
    wait_rises(22, to);
    repeat (3) @(negedge clk);
    n_chk++; if (dht_oe_o !== 1'b1 || to) $display("FAIL rstmid_in_bit20_low got %b want 1", dht_oe_o); else n_pass++;
    d0 = n_done; e0 = n_err;
    rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({dht_oe_o, busy_o, done_o, err_o} !== 4'b0000)
      $display("FAIL rstmid_outputs got %b want 0000", {dht_oe_o, busy_o, done_o, err_o});
    else n_pass++;
    @(negedge clk);
    rst_ni = 1'b1;
    saw = 1'b0;
    repeat (100 * DIV) begin
      @(negedge clk);
      if (dht_oe_o || busy_o) saw = 1'b1;
    end
    n_chk++; if (saw !== 1'b0) $display("FAIL rstmid_quiet got %b want 0", saw); else n_pass++;
    n_chk++;
    if (n_done !== d0 || n_err !== e0)
      $display("FAIL rstmid_pulses got done=%0d err=%0d want done=%0d err=%0d", n_done, n_err, d0, e0);
    else n_pass++;
  endtask

  task automatic test_input_latch();
    logic [39:0] f, e;
    int ack, rl, rh, el;
    logic de, be, to;
    hum_i = 8'd25; temp_i = 8'd25;
    exp_q.push_back({8'd25, 8'h00, 8'd25, 8'h00, 8'd50});
    host_start(150);
    fork
      rx_frame(f, ack, rl, rh, el, de, be, to);
      begin
        repeat (1000) @(negedge clk);
        temp_i = 8'd30;
      end
    join
    e = exp_q.pop_front();
    n_chk++; if (f !== e || to) $display("FAIL latch_inflight_frame got %h want %h", f, e); else n_pass++;
    exp_q.push_back({8'd25, 8'h00, 8'd30, 8'h00, 8'd55});
    host_start(150);
    rx_frame(f, ack, rl, rh, el, de, be, to);
    e = exp_q.pop_front();
    n_chk++; if (f !== e || to) $display("FAIL latch_next_frame got %h want %h", f, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_collision();
    test_reset_mid_frame();
    test_input_latch();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
